k_fifo_2deep_rv: RTL
====================

Name: k_fifo_2deep_rv

Overview:
- Two-entry synchronous FIFO with valid/ready handshakes on both sides.
- Owns the write/read pointers and flags, and drives a 2-deep dual-port RAM: wen, waddr and raddr out, q back.
- Sits between a producer and a consumer in the FIFO subsystem, decoupling one cycle of backpressure.
- Also reports occupancy and supports a synchronous flush.

Parameters:
- data_size, 8, width of each data word in bits.
- addr_size, 1, RAM address width. Fixed at 1 (depth 2). Any other value is a synthesis-time error.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  data_size  write-side data word.
- in_valid  input  1  producer offers in_data this cycle.
- in_ready  output  1  FIFO accepts a word this cycle.
- out_data  output  data_size  word at the head of the FIFO.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer takes the head word this cycle.
- flush  input  1  synchronous clear of all entries.
- count  output  2  current occupancy, 0..2.

Behaviour:
- Reset (Already decided): one clock, clk; reset rst is asynchronous and active-high.
- On rst assertion, immediately: wptr=0, rptr=0, wrap bits=0, count=0, out_valid=0, in_ready=1.
- RAM contents are not reset. out_data is don't-care whenever out_valid=0.
- Pointers: wptr and rptr are 1-bit addresses, each with its own wrap bit.
  - empty = (wptr==rptr) and (wrap bits equal).
  - full = (wptr==rptr) and (wrap bits differ).
  - Each pointer increments modulo 2 and toggles its wrap bit when it passes from 1 to 0.
- Transfer events:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Flags:
  - in_ready = !full. Depends only on state, never on out_ready.
  - out_valid = !empty. Depends only on state, never on in_valid.
  - No combinational in-to-out path.
- Write: on push, wen=1 and waddr=wptr for that cycle. The word is stored at the rising edge and wptr advances at the same edge.
- Read: raddr=rptr at all times. out_data = RAM q (asynchronous read of mem[rptr]). On pop, rptr advances at the rising edge.
- Latency: a word pushed at edge N gives out_valid=1 and out_data=word from just after edge N. There is no same-cycle bypass when empty.
- count:
  - +1 on push only, -1 on pop only.
  - Unchanged on push&pop together, and unchanged when neither occurs.
  - Registered, and must always equal the occupancy implied by the pointers.
- Simultaneous push & pop:
  - With count=1: both happen; count stays 1; the popped word is the old head.
  - With count=2: push is impossible (in_ready=0); pop proceeds; count goes to 1 and in_ready=1 next cycle.
  - With count=0: pop is impossible (out_valid=0); push proceeds.
- Ordering: strict FIFO order is preserved across pointer wrap-around.
- flush:
  - At the next edge, pointers, wrap bits and count go to 0, overriding any push or pop in that cycle.
  - wen is forced to 0 while flush=1.
  - Any word offered in a flush cycle is not accepted, even though in_ready may read 1.
- rst mid-transfer: in-flight push/pop is discarded and all state returns to reset values asynchronously.
- Holding rules, for both sides of the handshake:
  - in_data must not be required to be held stable by the FIFO (it is sampled only at push).
  - out_data is stable while out_valid=1 and no pop occurs.

Decomposition:
- Shared package: the depth constant (2), the pointer width (1) and the count width (2).
- One sub-module: the existing team RAM k_dp_2deep_ram_t1, instantiated as the storage, driven by wen/waddr/raddr and returning q.
- The pointer, flag and count logic stays in this module, roughly 150 lines.

Test Plan:
- Reset then idle: rst pulse mid-cycle → count=0, out_valid=0, in_ready=1 immediately, without waiting for a clk edge.
- Fill: push 0xA1, then 0xB2 with out_ready=0 → count=1 then 2; in_ready=0 after the 2nd edge; out_data=0xA1.
- Drain with wrap: from full, out_ready=1 for 2 cycles → 0xA1 then 0xB2, count=0, out_valid=0. Then push 0xC3, 0xD4, 0xE5 interleaved with pops → order C3, D4, E5 is preserved across the pointer wrap.
- Simultaneous at count=1: head 0x11, push 0x22 and pop together → 0x11 consumed, count stays 1, out_data=0x22 next.
- Full backpressure: count=2, in_valid=1 and out_ready=1 → only the pop occurs; in_ready rises next cycle; the offered word is not written (wen=0).
- Flush: count=2, flush=1 together with in_valid=1 → count=0, out_valid=0 next cycle, no word written. A subsequent push of 0x5A yields out_data=0x5A.

Source files
------------

// File: rtl/k_fifo_2deep_rv_pkg.sv
// Shared sizing for the 2-deep valid/ready FIFO and a pointer-advance helper.
package k_fifo_2deep_rv_pkg;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned PTR_W      = 1;
  localparam int unsigned CNT_W      = 2;

  // {wrap, ptr} + 1: the wrap bit toggles exactly when ptr passes from 1 to 0.
  function automatic logic [PTR_W:0] ptr_inc(input logic [PTR_W:0] p);
    return p + {{PTR_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/k_dp_2deep_ram_t1.sv
// 2-deep dual-port RAM: synchronous write, asynchronous read; contents are not reset.
// Latency: a write is visible on q just after the write edge; no backpressure.
module k_dp_2deep_ram_t1 #(
  parameter int data_size = 8,
  parameter int addr_size = 1
) (
  input  logic                 clk,
  input  logic                 wen,
  input  logic [addr_size-1:0] waddr,
  input  logic [data_size-1:0] wdata,
  input  logic [addr_size-1:0] raddr,
  output logic [data_size-1:0] q
);

  logic [data_size-1:0] mem [2**addr_size];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  assign q = mem[raddr];

endmodule

// File: rtl/k_fifo_2deep_rv.sv
// 2-entry valid/ready FIFO; a pushed word is visible on out_data just after its edge, no bypass.
// in_ready = !full and out_valid = !empty, both from state only; flush clears at the next edge.
module k_fifo_2deep_rv
  import k_fifo_2deep_rv_pkg::*;
#(
  parameter int data_size = 8,
  parameter int addr_size = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [data_size-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [data_size-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush,
  output logic [CNT_W-1:0]     count
);

  generate
    if (addr_size != PTR_W) begin : g_bad_addr_size
      $error("k_fifo_2deep_rv: addr_size must be 1 (depth 2)");
    end
  endgenerate

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             wwrap_q, wwrap_d, rwrap_q, rwrap_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty, full, push, pop, wen;

  assign empty     = (wptr_q == rptr_q) && (wwrap_q == rwrap_q);
  assign full      = (wptr_q == rptr_q) && (wwrap_q != rwrap_q);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // A word offered during flush is dropped even though in_ready may read 1.
  assign wen       = push & ~flush;
  assign count     = count_q;

  always_comb begin
    {wwrap_d, wptr_d} = {wwrap_q, wptr_q};
    {rwrap_d, rptr_d} = {rwrap_q, rptr_q};
    count_d           = count_q;
    if (flush) begin
      {wwrap_d, wptr_d} = '0;
      {rwrap_d, rptr_d} = '0;
      count_d           = '0;
    end else begin
      if (push) begin
        {wwrap_d, wptr_d} = ptr_inc({wwrap_q, wptr_q});
      end
      if (pop) begin
        {rwrap_d, rptr_d} = ptr_inc({rwrap_q, rptr_q});
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      wwrap_q <= 1'b0;
      rwrap_q <= 1'b0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      wwrap_q <= wwrap_d;
      rwrap_q <= rwrap_d;
      count_q <= count_d;
    end
  end

  k_dp_2deep_ram_t1 #(
    .data_size (data_size),
    .addr_size (addr_size)
  ) u_ram (
    .clk   (clk),
    .wen   (wen),
    .waddr (wptr_q),
    .wdata (in_data),
    .raddr (rptr_q),
    .q     (out_data)
  );

endmodule
